// File: rtl/accumulator_sequencer_if.sv
// Control bundle between the accumulator-machine sequencer and its datapath.
//
// master : the sequencer. It reads start/step controls, the IR and the ACC flags.
//          It drives the register load enables, the mux selects, the ALU opcode,
//          the memory write enable, and status.
// slave  : the datapath / environment side (mirror directions).
//
// Signals
//   start, step_mode, step   run control
//   instruction[15:0]        IR contents, [15:12] opcode, [11:0] operand address
//   acc_zero, acc_neg        ACC == 0, ACC[15]
//   mar/mbr/ir/pc/acc write  register load enables, with their source selects
//   alu_op[3:0], mem_write   ALU function, main-memory write enable
//   busy, halted             status
//   instr_count              retired-instruction counter, COUNT_W bits
interface accumulator_sequencer_if #(
  parameter int unsigned COUNT_W = 16
) ();

  logic               start;
  logic               step_mode;
  logic               step;
  logic [15:0]        instruction;
  logic               acc_zero;
  logic               acc_neg;

  logic               mar_write;
  logic               mar_sel;
  logic               mbr_write;
  logic               mbr_sel;
  logic               ir_write;
  logic               pc_write;
  logic               pc_sel;
  logic               acc_write;
  logic [1:0]         acc_sel;
  logic [3:0]         alu_op;
  logic               mem_write;
  logic               busy;
  logic               halted;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    input  start, step_mode, step, instruction, acc_zero, acc_neg,
    output mar_write, mar_sel, mbr_write, mbr_sel, ir_write, pc_write, pc_sel,
           acc_write, acc_sel, alu_op, mem_write, busy, halted, instr_count
  );

  modport slave (
    output start, step_mode, step, instruction, acc_zero, acc_neg,
    input  mar_write, mar_sel, mbr_write, mbr_sel, ir_write, pc_write, pc_sel,
           acc_write, acc_sel, alu_op, mem_write, busy, halted, instr_count
  );

endinterface

// File: rtl/accumulator_sequencer.sv
// Multi-cycle control FSM for the 16-bit accumulator machine.
//
// The FSM fetches, decodes and executes one instruction at a time. It drives
// the load enables and mux selects of ACC/MAR/MBR/IR/PC, the ALU opcode and the
// main-memory write enable. Main memory reads are synchronous, with one cycle
// of latency from MAR.
//
// Ports
//   clock    system clock, rising edge
//   reset    asynchronous, active-low
//   ctrl_if  accumulator_sequencer_if.master (run control, IR/flags in, controls out)
//
// Parameters
//   COUNT_W      width of the retired-instruction counter (wraps)
//   STEP_ENABLE  1: pause after each retire while step_mode is high; 0: step_mode ignored
module accumulator_sequencer #(
  parameter int unsigned COUNT_W     = 16,
  parameter bit          STEP_ENABLE = 1'b1
) (
  input logic                     clock,
  input logic                     reset,
  accumulator_sequencer_if.master ctrl_if
);

  // Opcodes, instruction[15:12]
  localparam logic [3:0] OpHalt    = 4'h0;
  localparam logic [3:0] OpLoad    = 4'h1;
  localparam logic [3:0] OpStore   = 4'h2;
  localparam logic [3:0] OpAdd     = 4'h3;
  localparam logic [3:0] OpSub     = 4'h4;
  localparam logic [3:0] OpAnd     = 4'h5;
  localparam logic [3:0] OpOr      = 4'h6;
  localparam logic [3:0] OpXor     = 4'h7;
  localparam logic [3:0] OpJump    = 4'h8;
  localparam logic [3:0] OpSkipz   = 4'h9;
  localparam logic [3:0] OpSkipneg = 4'hA;
  localparam logic [3:0] OpShl     = 4'hB;
  localparam logic [3:0] OpShr     = 4'hC;
  localparam logic [3:0] OpClear   = 4'hE;

  // ALU function codes
  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluShl = 4'b0100;
  localparam logic [3:0] AluShr = 4'b0101;
  localparam logic [3:0] AluAnd = 4'b1000;
  localparam logic [3:0] AluOr  = 4'b1001;
  localparam logic [3:0] AluXor = 4'b1010;

  // ACC source selects
  localparam logic [1:0] AccFromAlu  = 2'd0;
  localparam logic [1:0] AccFromMbr  = 2'd1;
  localparam logic [1:0] AccFromZero = 2'd2;

  typedef enum logic [3:0] {
    StIdle,
    StF0,
    StF1,
    StF2,
    StF3,
    StDec,
    StE0,
    StE1,
    StE2,
    StE3,
    StS0,
    StS1,
    StPause,
    StHalted
  } state_e;

  state_e             r_state;
  state_e             w_state_next;
  state_e             w_after_retire;
  logic [COUNT_W-1:0] r_count;

  logic [3:0] w_opcode;
  logic       w_unused_operand;
  logic       w_retire;

  logic       w_mar_write;
  logic       w_mar_sel;
  logic       w_mbr_write;
  logic       w_mbr_sel;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_pc_sel;
  logic       w_acc_write;
  logic [1:0] w_acc_sel;
  logic [3:0] w_alu_op;
  logic       w_mem_write;

  assign w_opcode = ctrl_if.instruction[15:12];
  // The operand address goes straight from IR to the MAR/PC muxes in the datapath.
  assign w_unused_operand = ^ctrl_if.instruction[11:0];

  // Where to go after retiring an instruction.
  assign w_after_retire = (STEP_ENABLE && ctrl_if.step_mode) ? StPause : StF0;

  // ---------------------------------------------------------------------------
  // State and retired-instruction counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_retire) begin
        r_count <= r_count + COUNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and Moore-decoded controls
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_retire     = 1'b0;
    w_mar_write  = 1'b0;
    w_mar_sel    = 1'b0;
    w_mbr_write  = 1'b0;
    w_mbr_sel    = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_sel     = 1'b0;
    w_acc_write  = 1'b0;
    w_acc_sel    = AccFromAlu;
    w_alu_op     = AluAdd;
    w_mem_write  = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (ctrl_if.start) begin
          w_state_next = StF0;
        end
      end

      // Fetch: MAR <= PC, PC <= PC+1 while the read is in flight,
      // MBR <= mem, IR <= MBR.
      StF0: begin
        w_mar_write  = 1'b1;
        w_state_next = StF1;
      end
      StF1: begin
        w_pc_write   = 1'b1;
        w_state_next = StF2;
      end
      StF2: begin
        w_mbr_write  = 1'b1;
        w_state_next = StF3;
      end
      StF3: begin
        w_ir_write   = 1'b1;
        w_state_next = StDec;
      end

      StDec: begin
        case (w_opcode)
          OpHalt:  w_state_next = StHalted;
          OpStore: w_state_next = StS0;
          OpLoad, OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
            w_state_next = StE0;
          end
          OpJump: begin
            w_pc_write   = 1'b1;
            w_pc_sel     = 1'b1;
            w_retire     = 1'b1;
            w_state_next = w_after_retire;
          end
          // PC already points past the skip; one more increment skips the next word.
          OpSkipz: begin
            w_pc_write   = ctrl_if.acc_zero;
            w_retire     = 1'b1;
            w_state_next = w_after_retire;
          end
          OpSkipneg: begin
            w_pc_write   = ctrl_if.acc_neg;
            w_retire     = 1'b1;
            w_state_next = w_after_retire;
          end
          OpShl: begin
            w_acc_write  = 1'b1;
            w_alu_op     = AluShl;
            w_retire     = 1'b1;
            w_state_next = w_after_retire;
          end
          OpShr: begin
            w_acc_write  = 1'b1;
            w_alu_op     = AluShr;
            w_retire     = 1'b1;
            w_state_next = w_after_retire;
          end
          OpClear: begin
            w_acc_write  = 1'b1;
            w_acc_sel    = AccFromZero;
            w_retire     = 1'b1;
            w_state_next = w_after_retire;
          end
          // NOP (0xD, 0xF)
          default: begin
            w_retire     = 1'b1;
            w_state_next = w_after_retire;
          end
        endcase
      end

      // Memory-operand execute: MAR <= IR[11:0], read wait, MBR <= mem, ACC update.
      StE0: begin
        w_mar_write  = 1'b1;
        w_mar_sel    = 1'b1;
        w_state_next = StE1;
      end
      StE1: begin
        w_state_next = StE2;
      end
      StE2: begin
        w_mbr_write  = 1'b1;
        w_state_next = StE3;
      end
      StE3: begin
        w_acc_write = 1'b1;
        case (w_opcode)
          OpLoad:  w_acc_sel = AccFromMbr;
          OpSub:   w_alu_op  = AluSub;
          OpAnd:   w_alu_op  = AluAnd;
          OpOr:    w_alu_op  = AluOr;
          OpXor:   w_alu_op  = AluXor;
          default: w_alu_op  = AluAdd;
        endcase
        w_retire     = 1'b1;
        w_state_next = w_after_retire;
      end

      // Store: address and data are captured together, written the next cycle.
      StS0: begin
        w_mar_write  = 1'b1;
        w_mar_sel    = 1'b1;
        w_mbr_write  = 1'b1;
        w_mbr_sel    = 1'b1;
        w_state_next = StS1;
      end
      StS1: begin
        w_mem_write  = 1'b1;
        w_retire     = 1'b1;
        w_state_next = w_after_retire;
      end

      StPause: begin
        if (ctrl_if.step || !ctrl_if.step_mode) begin
          w_state_next = StF0;
        end
      end

      // Only reset leaves HALTED.
      StHalted: begin
        w_state_next = StHalted;
      end

      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  assign ctrl_if.mar_write   = w_mar_write;
  assign ctrl_if.mar_sel     = w_mar_sel;
  assign ctrl_if.mbr_write   = w_mbr_write;
  assign ctrl_if.mbr_sel     = w_mbr_sel;
  assign ctrl_if.ir_write    = w_ir_write;
  assign ctrl_if.pc_write    = w_pc_write;
  assign ctrl_if.pc_sel      = w_pc_sel;
  assign ctrl_if.acc_write   = w_acc_write;
  assign ctrl_if.acc_sel     = w_acc_sel;
  assign ctrl_if.alu_op      = w_alu_op;
  assign ctrl_if.mem_write   = w_mem_write;
  assign ctrl_if.busy        = (r_state != StIdle) && (r_state != StHalted);
  assign ctrl_if.halted      = (r_state == StHalted);
  assign ctrl_if.instr_count = r_count;

endmodule

// File: tb/tb_accumulator_sequencer.sv
module tb_accumulator_sequencer;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic rst4_n  = 1'b0;

  always #5 clock = ~clock;

  accumulator_sequencer_if #(.COUNT_W(16)) bus ();
  accumulator_sequencer_if #(.COUNT_W(4))  bus4 ();

  accumulator_sequencer #(.COUNT_W(16), .STEP_ENABLE(1'b1)) dut (
    .clock   (clock),
    .reset   (reset_n),
    .ctrl_if (bus)
  );

  accumulator_sequencer #(.COUNT_W(4), .STEP_ENABLE(1'b1)) dut4 (
    .clock   (clock),
    .reset   (rst4_n),
    .ctrl_if (bus4)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Datapath model: registers, memory, ALU, all driven by the DUT controls
  // ---------------------------------------------------------------------------
  logic [15:0] mem [4096];
  logic [15:0] pc, mar, mbr, ir, acc, dout;
  logic        dp_clear = 1'b0;
  logic [15:0] dp_pc0   = '0;
  logic [15:0] dp_acc0  = '0;
  logic        ld_en    = 1'b0;
  logic [11:0] ld_addr  = '0;
  logic [15:0] ld_data  = '0;

  function automatic logic [15:0] alu(input logic [3:0] op, input logic [15:0] a,
                                      input logic [15:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b1000: return a & b;
      4'b1001: return a | b;
      4'b1010: return a ^ b;
      4'b0100: return a << 1;
      4'b0101: return a >> 1;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clock) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (dp_clear) begin
      pc   <= dp_pc0;
      acc  <= dp_acc0;
      mar  <= '0;
      mbr  <= '0;
      ir   <= '0;
      dout <= '0;
    end else begin
      dout <= mem[mar[11:0]];
      if (bus.mar_write) mar <= bus.mar_sel ? {4'h0, ir[11:0]} : pc;
      if (bus.mbr_write) mbr <= bus.mbr_sel ? acc : dout;
      if (bus.ir_write)  ir  <= mbr;
      if (bus.pc_write)  pc  <= bus.pc_sel ? {4'h0, ir[11:0]} : pc + 16'd1;
      if (bus.acc_write) begin
        case (bus.acc_sel)
          2'd0:    acc <= alu(bus.alu_op, acc, mbr);
          2'd1:    acc <= mbr;
          default: acc <= 16'h0000;
        endcase
      end
      if (bus.mem_write) mem[mar[11:0]] <= mbr;
    end
  end

  assign bus.instruction = ir;
  assign bus.acc_zero    = (acc == 16'h0000);
  assign bus.acc_neg     = acc[15];

  assign bus4.instruction = 16'hD000;
  assign bus4.acc_zero    = 1'b0;
  assign bus4.acc_neg     = 1'b0;
  assign bus4.step_mode   = 1'b0;
  assign bus4.step        = 1'b0;

  logic [14:0] ctrl_v;
  assign ctrl_v = {bus.mar_write, bus.mar_sel, bus.mbr_write, bus.mbr_sel, bus.ir_write,
                   bus.pc_write, bus.pc_sel, bus.acc_write, bus.acc_sel, bus.alu_op,
                   bus.mem_write};

  // ---------------------------------------------------------------------------
  // Scoreboard: expected memory writes, ALU opcodes and fetch addresses
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [11:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t         wq [$];
  logic [3:0]  aq [$];
  logic [15:0] fq [$];
  bit          chk_fetch = 1'b0;
  wr_t         mon_w;
  logic [3:0]  mon_a;
  logic [15:0] mon_f;

  always @(negedge clock) begin
    if (bus.mem_write) begin
      checks++;
      assert (wq.size() != 0) else begin
        errors++;
        $error("FAIL mem_write_unexpected got addr=%0h data=%0h exp no write", mar[11:0], mbr);
      end
      if (wq.size() != 0) begin
        mon_w = wq.pop_front();
        checks++;
        assert ({mar[11:0], mbr} === {mon_w.addr, mon_w.data}) else begin
          errors++;
          $error("FAIL mem_write got addr=%0h data=%0h exp addr=%0h data=%0h",
                 mar[11:0], mbr, mon_w.addr, mon_w.data);
        end
        if (mon_w.cyc >= 0) begin
          checks++;
          assert (cyc === mon_w.cyc) else begin
            errors++;
            $error("FAIL mem_write_cycle got %0d exp %0d", cyc, mon_w.cyc);
          end
        end
      end
    end
    if (bus.acc_write && bus.acc_sel == 2'd0) begin
      checks++;
      assert (aq.size() != 0) else begin
        errors++;
        $error("FAIL alu_unexpected got op=%0b exp none", bus.alu_op);
      end
      if (aq.size() != 0) begin
        mon_a = aq.pop_front();
        checks++;
        assert (bus.alu_op === mon_a) else begin
          errors++;
          $error("FAIL alu_op got %0b exp %0b", bus.alu_op, mon_a);
        end
      end
    end
    if (chk_fetch && bus.mar_write && !bus.mar_sel) begin
      checks++;
      assert (fq.size() != 0) else begin
        errors++;
        $error("FAIL fetch_unexpected got pc=%0h exp none", pc);
      end
      if (fq.size() != 0) begin
        mon_f = fq.pop_front();
        checks++;
        assert (pc === mon_f) else begin
          errors++;
          $error("FAIL fetch_pc got %0h exp %0h", pc, mon_f);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clock);
    ld_en   = 1'b0;
  endtask

  task automatic dp_init(input logic [15:0] pc0, input logic [15:0] acc0);
    dp_pc0   = pc0;
    dp_acc0  = acc0;
    dp_clear = 1'b1;
    @(negedge clock);
    dp_clear = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  // Returns the cycle number of the first F0.
  task automatic start_run(output int c0);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_halt(input int limit, output int hc);
    int n = 0;
    while (!bus.halted && n < limit) begin
      @(negedge clock);
      n++;
    end
    check("halt_reached", {31'b0, bus.halted}, 32'd1);
    hc = cyc;
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [15:0] d, input int c);
    wr_t w;
    w.addr = a;
    w.data = d;
    w.cyc  = c;
    wq.push_back(w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int c0;
    int hc;
    bus.start      = 1'b0;
    bus.step_mode  = 1'b0;
    bus.step       = 1'b0;
    bus4.start     = 1'b0;

    // Reset state
    #1;
    check("rst_ctrl", {17'b0, ctrl_v}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_halted", {31'b0, bus.halted}, 32'd0);
    check("rst_count", {16'b0, bus.instr_count}, 32'd0);
    check("rst4_count", {28'b0, bus4.instr_count}, 32'd0);

    // Program 1: LOAD 10; ADD 11; STORE 12; HALT
    @(negedge clock);
    poke(12'd0, 16'h100A);
    poke(12'd1, 16'h300B);
    poke(12'd2, 16'h200C);
    poke(12'd3, 16'h0000);
    poke(12'd10, 16'd5);
    poke(12'd11, 16'd7);
    poke(12'd12, 16'hDEAD);
    dp_init(16'd0, 16'd0);
    reset_n = 1'b1;
    tick(1);
    check("idle_busy", {31'b0, bus.busy}, 32'd0);
    aq.push_back(4'b0000);
    start_run(c0);
    push_wr(12'd12, 16'd12, c0 + 24);
    check("f0_busy", {31'b0, bus.busy}, 32'd1);
    wait_halt(60, hc);
    check("p1_halt_cycle", hc - c0, 32'd30);
    check("p1_count", {16'b0, bus.instr_count}, 32'd3);
    check("p1_acc", {16'b0, acc}, 32'd12);
    check("p1_mem12", {16'b0, mem[12]}, 32'd12);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(3);
    check("p1_start_ignored_halted", {31'b0, bus.halted}, 32'd1);
    check("p1_start_ignored_busy", {31'b0, bus.busy}, 32'd0);
    check("p1_halted_ctrl", {17'b0, ctrl_v}, 32'd0);
    check("p1_wq_empty", wq.size(), 32'd0);

    // Program 2: SUB/AND/OR/XOR on 0x00F0 vs 0x0F0F, then SHL/SHR
    do_reset();
    poke(12'd0,  16'h1040);
    poke(12'd1,  16'h4041);
    poke(12'd2,  16'h2050);
    poke(12'd3,  16'h1040);
    poke(12'd4,  16'h5041);
    poke(12'd5,  16'h2051);
    poke(12'd6,  16'h1040);
    poke(12'd7,  16'h6041);
    poke(12'd8,  16'h2052);
    poke(12'd9,  16'h1040);
    poke(12'd10, 16'h7041);
    poke(12'd11, 16'h2053);
    poke(12'd12, 16'hB000);
    poke(12'd13, 16'h2054);
    poke(12'd14, 16'hC000);
    poke(12'd15, 16'h2055);
    poke(12'd16, 16'h0000);
    poke(12'h040, 16'h00F0);
    poke(12'h041, 16'h0F0F);
    dp_init(16'd0, 16'd0);
    aq.push_back(4'b0001);
    aq.push_back(4'b1000);
    aq.push_back(4'b1001);
    aq.push_back(4'b1010);
    aq.push_back(4'b0100);
    aq.push_back(4'b0101);
    push_wr(12'h050, 16'hF1E1, -1);
    push_wr(12'h051, 16'h0000, -1);
    push_wr(12'h052, 16'h0FFF, -1);
    push_wr(12'h053, 16'h0FFF, -1);
    push_wr(12'h054, 16'h1FFE, -1);
    push_wr(12'h055, 16'h0FFF, -1);
    start_run(c0);
    wait_halt(300, hc);
    check("p2_count", {16'b0, bus.instr_count}, 32'd16);
    check("p2_wq_empty", wq.size(), 32'd0);
    check("p2_aq_empty", aq.size(), 32'd0);

    // Program 3: JUMP, SKIPZ taken / not taken, SKIPNEG taken, CLEAR
    do_reset();
    poke(12'd0,  16'h8008);
    poke(12'd8,  16'h9000);
    poke(12'd9,  16'h0000);
    poke(12'd10, 16'h1020);
    poke(12'd11, 16'h9000);
    poke(12'd12, 16'h1021);
    poke(12'd13, 16'hA000);
    poke(12'd14, 16'h0000);
    poke(12'd15, 16'h2030);
    poke(12'd16, 16'hE000);
    poke(12'd17, 16'h2031);
    poke(12'd18, 16'h0000);
    poke(12'h020, 16'h0001);
    poke(12'h021, 16'h8000);
    dp_init(16'd0, 16'd0);
    fq.push_back(16'd0);
    fq.push_back(16'd8);
    fq.push_back(16'd10);
    fq.push_back(16'd11);
    fq.push_back(16'd12);
    fq.push_back(16'd13);
    fq.push_back(16'd15);
    fq.push_back(16'd16);
    fq.push_back(16'd17);
    fq.push_back(16'd18);
    push_wr(12'h030, 16'h8000, -1);
    push_wr(12'h031, 16'h0000, -1);
    chk_fetch = 1'b1;
    start_run(c0);
    wait_halt(200, hc);
    chk_fetch = 1'b0;
    check("p3_count", {16'b0, bus.instr_count}, 32'd9);
    check("p3_pc_end", {16'b0, pc}, 32'd19);
    check("p3_fq_empty", fq.size(), 32'd0);
    check("p3_wq_empty", wq.size(), 32'd0);

    // Program 4: single-step with two NOPs
    do_reset();
    poke(12'd0, 16'hD000);
    poke(12'd1, 16'hF000);
    poke(12'd2, 16'h0000);
    dp_init(16'd0, 16'd0);
    bus.step_mode = 1'b1;
    start_run(c0);
    tick(5);
    check("pause1_busy", {31'b0, bus.busy}, 32'd1);
    check("pause1_ctrl", {17'b0, ctrl_v}, 32'd0);
    check("pause1_count", {16'b0, bus.instr_count}, 32'd1);
    tick(2);
    check("pause1_hold_ctrl", {17'b0, ctrl_v}, 32'd0);
    bus.step = 1'b1;
    @(negedge clock);
    bus.step = 1'b0;
    check("step_to_f0", {31'b0, bus.mar_write}, 32'd1);
    tick(2);
    check("f2_mbr_write", {31'b0, bus.mbr_write}, 32'd1);
    bus.step = 1'b1;
    @(negedge clock);
    bus.step = 1'b0;
    check("f2_step_ignored", {31'b0, bus.ir_write}, 32'd1);
    tick(2);
    check("pause2_ctrl", {17'b0, ctrl_v}, 32'd0);
    check("pause2_count", {16'b0, bus.instr_count}, 32'd2);
    tick(1);
    check("pause2_hold_mar", {31'b0, bus.mar_write}, 32'd0);
    check("pause2_hold_busy", {31'b0, bus.busy}, 32'd1);
    bus.step_mode = 1'b0;
    @(negedge clock);
    check("mode_off_to_f0", {31'b0, bus.mar_write}, 32'd1);
    wait_halt(20, hc);
    check("p4_halt_cycle", hc - c0, 32'd20);
    check("p4_count", {16'b0, bus.instr_count}, 32'd2);

    // Program 5: reset in S0 of a STORE
    do_reset();
    poke(12'd0, 16'hD000);
    poke(12'd1, 16'h2005);
    poke(12'd2, 16'h0000);
    poke(12'd5, 16'hAAAA);
    dp_init(16'd0, 16'h1234);
    start_run(c0);
    tick(10);
    check("s0_ctrl", {17'b0, ctrl_v}, 32'h7800);
    check("s0_count", {16'b0, bus.instr_count}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_ctrl", {17'b0, ctrl_v}, 32'd0);
    check("async_rst_busy", {31'b0, bus.busy}, 32'd0);
    check("async_rst_count", {16'b0, bus.instr_count}, 32'd0);
    @(negedge clock);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    check("post_rst_busy", {31'b0, bus.busy}, 32'd0);
    check("post_rst_halted", {31'b0, bus.halted}, 32'd0);
    check("post_rst_ctrl", {17'b0, ctrl_v}, 32'd0);
    check("post_rst_count", {16'b0, bus.instr_count}, 32'd0);
    check("post_rst_mem5", {16'b0, mem[5]}, 32'h0000AAAA);

    // COUNT_W=4 instance: NOPs forever, counter wraps 15 -> 0 -> 1
    rst4_n = 1'b1;
    tick(1);
    bus4.start = 1'b1;
    @(negedge clock);
    bus4.start = 1'b0;
    tick(75);
    check("wrap_15", {28'b0, bus4.instr_count}, 32'd15);
    tick(5);
    check("wrap_0", {28'b0, bus4.instr_count}, 32'd0);
    tick(5);
    check("wrap_1", {28'b0, bus4.instr_count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
